// File: rtl/kmac_msg_absorb.sv
// kmac_msg_absorb: absorbs message words into the Keccak state one word per
// cycle, requests a permutation after every full rate block, and on the
// end-of-message marker appends the pad byte, zero-fills the rest of the
// block, sets the final bit, and runs the last permutation.

module kmac_msg_absorb #(
    parameter int          MsgWidth   = 64,
    parameter int          BlockWords = 17,
    parameter logic [7:0]  PadByte    = 8'h06,
    localparam int         BlockW     = $clog2(BlockWords)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  msg_valid_i,
    input  logic [MsgWidth-1:0]   msg_data_i,
    input  logic [MsgWidth/8-1:0] msg_strb_i,
    output logic                  msg_ready_o,
    input  logic                  process_i,
    input  logic                  clear_i,
    output logic                  keccak_valid_o,
    output logic [BlockW-1:0]     keccak_addr_o,
    output logic [MsgWidth-1:0]   keccak_data_o,
    output logic                  run_o,
    input  logic                  run_done_i,
    output logic                  absorbed_o
);

    localparam int StrbW = MsgWidth / 8;
    localparam int NbW   = $clog2(StrbW + 1);

    // Final-bit word: 0x80 in the most significant byte of the last rate word.
    localparam logic [MsgWidth-1:0] LastBit = {8'h80, {(MsgWidth-8){1'b0}}};

    typedef enum logic [2:0] {
        StAbsorb,
        StRun,
        StPad,
        StZero,
        StPadRun,
        StWait
    } state_e;

    state_e                state, state_next;
    logic [BlockW-1:0]     cnt, cnt_next;
    logic [MsgWidth-1:0]   held, held_next;
    logic [NbW-1:0]        nbytes, nbytes_next;
    logic                  held_vld, held_vld_next;
    logic                  pending, pending_next;
    logic                  run_q, run_next;
    logic                  absorbed_q, absorbed_next;

    logic                  strb_full;
    logic [NbW-1:0]        strb_count;
    logic [MsgWidth-1:0]   masked_data;
    logic [MsgWidth-1:0]   pad_word;
    logic                  last_word;

    // Decode the incoming strobe: full-word test, byte count, and data with
    // unstrobed bytes forced to zero.
    always_comb begin
        strb_full   = &msg_strb_i;
        strb_count  = '0;
        masked_data = '0;
        for (int i = 0; i < StrbW; i++) begin
            strb_count = strb_count + NbW'(msg_strb_i[i]);
            masked_data[8*i +: 8] = msg_strb_i[i] ? msg_data_i[8*i +: 8] : 8'h00;
        end
    end

    // Held partial bytes followed by the pad byte at the first free position.
    assign pad_word  = held | (MsgWidth'(PadByte) << {nbytes, 3'b000});
    assign last_word = (cnt == BlockW'(BlockWords - 1));

    // Next-state and output decode; clear overrides every other event last.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        held_next      = held;
        nbytes_next    = nbytes;
        held_vld_next  = held_vld;
        pending_next   = pending;
        run_next       = 1'b0;
        absorbed_next  = 1'b0;
        msg_ready_o    = 1'b0;
        keccak_valid_o = 1'b0;
        keccak_addr_o  = cnt;
        keccak_data_o  = '0;

        unique case (state)
            StAbsorb: begin
                msg_ready_o = !held_vld;
                if (msg_valid_i && !held_vld && strb_full) begin
                    keccak_valid_o = 1'b1;
                    keccak_data_o  = msg_data_i;
                    if (last_word) begin
                        cnt_next     = '0;
                        state_next   = StRun;
                        run_next     = 1'b1;
                        pending_next = process_i;
                    end else begin
                        cnt_next = cnt + BlockW'(1);
                        if (process_i) state_next = StPad;
                    end
                end else if (msg_valid_i && !held_vld) begin
                    held_next     = masked_data;
                    nbytes_next   = strb_count;
                    held_vld_next = 1'b1;
                    if (process_i) state_next = StPad;
                end else if (process_i) begin
                    state_next = StPad;
                end
            end

            StRun: begin
                if (run_done_i) begin
                    state_next   = (pending || process_i) ? StPad : StAbsorb;
                    pending_next = 1'b0;
                end else if (process_i) begin
                    pending_next = 1'b1;
                end
            end

            StPad: begin
                keccak_valid_o = 1'b1;
                if (last_word) begin
                    keccak_data_o = pad_word | LastBit;
                    cnt_next      = '0;
                    state_next    = StPadRun;
                    run_next      = 1'b1;
                end else begin
                    keccak_data_o = pad_word;
                    cnt_next      = cnt + BlockW'(1);
                    state_next    = StZero;
                end
            end

            StZero: begin
                keccak_valid_o = 1'b1;
                if (last_word) begin
                    keccak_data_o = LastBit;
                    cnt_next      = '0;
                    state_next    = StPadRun;
                    run_next      = 1'b1;
                end else begin
                    cnt_next = cnt + BlockW'(1);
                end
            end

            StPadRun: begin
                if (run_done_i) begin
                    absorbed_next = 1'b1;
                    state_next    = StWait;
                end
            end

            StWait: begin
            end

            default: begin
                state_next = StAbsorb;
            end
        endcase

        if (clear_i) begin
            state_next    = StAbsorb;
            cnt_next      = '0;
            held_next     = '0;
            nbytes_next   = '0;
            held_vld_next = 1'b0;
            pending_next  = 1'b0;
            run_next      = 1'b0;
            absorbed_next = 1'b0;
        end
    end

    // State, counters, held word and the registered run/absorbed pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= StAbsorb;
            cnt        <= '0;
            held       <= '0;
            nbytes     <= '0;
            held_vld   <= 1'b0;
            pending    <= 1'b0;
            run_q      <= 1'b0;
            absorbed_q <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            held       <= held_next;
            nbytes     <= nbytes_next;
            held_vld   <= held_vld_next;
            pending    <= pending_next;
            run_q      <= run_next;
            absorbed_q <= absorbed_next;
        end
    end

    assign run_o      = run_q;
    assign absorbed_o = absorbed_q;

endmodule

// File: tb/tb_kmac_msg_absorb.sv
// tb_kmac_msg_absorb: drives byte-level messages into kmac_msg_absorb and
// checks every state write against a padded-message model, plus run/absorb
// pulse behaviour, clear and reset handling.

module tb_kmac_msg_absorb;

    localparam int MsgWidth   = 64;
    localparam int BlockWords = 17;
    localparam int BlockW     = $clog2(BlockWords);
    localparam int RateBytes  = BlockWords * 8;

    typedef logic [7:0] byte_q_t [$];
    typedef struct packed {
        logic [BlockW-1:0]   addr;
        logic [MsgWidth-1:0] data;
    } wr_t;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  msg_valid_i;
    logic [MsgWidth-1:0]   msg_data_i;
    logic [MsgWidth/8-1:0] msg_strb_i;
    logic                  msg_ready_o;
    logic                  process_i;
    logic                  clear_i;
    logic                  keccak_valid_o;
    logic [BlockW-1:0]     keccak_addr_o;
    logic [MsgWidth-1:0]   keccak_data_o;
    logic                  run_o;
    logic                  run_done_i;
    logic                  absorbed_o;

    logic auto_done;
    logic manual_done;
    bit   auto_run;
    int   min_delay;

    wr_t               exp_q [$];
    logic [MsgWidth-1:0] last_data [BlockWords];
    int  n_vectors;
    int  n_miscompares;
    int  run_seen;
    int  abs_seen;
    int  n_writes;
    bit  prev_wr_last;
    bit  clr_edge;

    assign run_done_i = auto_done | manual_done;

    kmac_msg_absorb #(
        .MsgWidth   (MsgWidth),
        .BlockWords (BlockWords),
        .PadByte    (8'h06)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .msg_valid_i    (msg_valid_i),
        .msg_data_i     (msg_data_i),
        .msg_strb_i     (msg_strb_i),
        .msg_ready_o    (msg_ready_o),
        .process_i      (process_i),
        .clear_i        (clear_i),
        .keccak_valid_o (keccak_valid_o),
        .keccak_addr_o  (keccak_addr_o),
        .keccak_data_o  (keccak_data_o),
        .run_o          (run_o),
        .run_done_i     (run_done_i),
        .absorbed_o     (absorbed_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Keccak padding at message level: pad byte, zero fill, final bit.
    function automatic byte_q_t pad_msg(input byte_q_t m);
        byte_q_t p = m;
        p.push_back(8'h06);
        while (p.size() % RateBytes != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        return p;
    endfunction

    // Every 8-byte little-endian word of the stream lands at index mod 17.
    task automatic push_words(input byte_q_t p);
        for (int w = 0; w < p.size() / 8; w++) begin
            logic [63:0] d;
            for (int b = 0; b < 8; b++) d[8*b +: 8] = p[8*w + b];
            exp_q.push_back('{addr: BlockW'(w % BlockWords), data: d});
        end
    endtask

    // Remember the clear value the DUT saw at each rising edge.
    always @(posedge clk_i) clr_edge = clear_i;

    // Compare process: every write against the model queue, run_o timing
    // every cycle (one cycle after a write to the last word, unless cleared).
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_wr_last = 1'b0;
        end else begin
            check_output("run_o timing", 64'(run_o), 64'(prev_wr_last && !clr_edge));
            if (run_o) run_seen++;
            if (absorbed_o) abs_seen++;
            if (keccak_valid_o) begin
                n_writes++;
                if (int'(keccak_addr_o) < BlockWords) last_data[keccak_addr_o] = keccak_data_o;
                if (exp_q.size() == 0) begin
                    check_output("unexpected write", 64'(keccak_valid_o), 64'(0));
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check_output("write addr", 64'(keccak_addr_o), 64'(e.addr));
                    check_output("write data", keccak_data_o, e.data);
                end
            end
            prev_wr_last = keccak_valid_o && (int'(keccak_addr_o) == BlockWords - 1);
        end
    end

    // Permutation responder: answers each run_o after a random latency.
    initial begin
        auto_done = 1'b0;
        forever begin
            @(negedge clk_i);
            if (auto_run && run_o) begin
                repeat ($urandom_range(min_delay, min_delay + 4)) @(negedge clk_i);
                auto_done = 1'b1;
                @(negedge clk_i);
                auto_done = 1'b0;
            end
        end
    end

    task automatic send_word(input logic [63:0] d, input logic [7:0] s);
        int t = 0;
        @(negedge clk_i);
        while (!msg_ready_o && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 500) check_output("ready timeout", 64'(msg_ready_o), 64'(1));
        msg_valid_i = 1'b1;
        msg_data_i  = d;
        msg_strb_i  = s;
        @(posedge clk_i);
        #1;
        msg_valid_i = 1'b0;
        msg_strb_i  = '0;
        msg_data_i  = {$urandom, $urandom};
    endtask

    task automatic apply_stimulus(input byte_q_t m);
        int nfull = m.size() / 8;
        int rem   = m.size() % 8;
        logic [63:0] d;
        for (int w = 0; w < nfull; w++) begin
            for (int b = 0; b < 8; b++) d[8*b +: 8] = m[8*w + b];
            send_word(d, 8'hFF);
        end
        if (rem != 0) begin
            d = {$urandom, $urandom};
            for (int b = 0; b < rem; b++) d[8*b +: 8] = m[8*nfull + b];
            send_word(d, 8'((1 << rem) - 1));
        end
    endtask

    task automatic pulse_process();
        @(negedge clk_i);
        process_i = 1'b1;
        @(posedge clk_i);
        #1 process_i = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk_i);
        clear_i = 1'b1;
        @(posedge clk_i);
        #1 clear_i = 1'b0;
    endtask

    // Full message: feed, mark end, wait for the single absorbed pulse.
    task automatic run_message(input byte_q_t m);
        byte_q_t p = pad_msg(m);
        int run0 = run_seen;
        int abs0 = abs_seen;
        int t = 0;
        push_words(p);
        apply_stimulus(m);
        pulse_process();
        while (abs_seen == abs0 && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        repeat (3) @(negedge clk_i);
        check_output("absorbed_o count", 64'(abs_seen - abs0), 64'(1));
        check_output("run_o count", 64'(run_seen - run0), 64'(p.size() / RateBytes));
        check_output("writes left", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        pulse_clear();
        @(negedge clk_i);
        check_output("ready after clear", 64'(msg_ready_o), 64'(1));
    endtask

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        byte_q_t m;
        int      base_w;
        int      run0;
        int      abs0;
        int      t;

        rst_ni      = 1'b0;
        msg_valid_i = 1'b0;
        msg_data_i  = '0;
        msg_strb_i  = '0;
        process_i   = 1'b0;
        clear_i     = 1'b0;
        manual_done = 1'b0;
        auto_run    = 1'b1;
        min_delay   = 0;

        #12;
        check_output("reset msg_ready_o", 64'(msg_ready_o), 64'(1));
        check_output("reset keccak_valid_o", 64'(keccak_valid_o), 64'(0));
        check_output("reset run_o", 64'(run_o), 64'(0));
        check_output("reset absorbed_o", 64'(absorbed_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        $display("[TB] 17 full words, held run");
        auto_run = 1'b0;
        m = {};
        for (int w = 0; w < BlockWords; w++)
            for (int b = 0; b < 8; b++) m.push_back(b == 0 ? 8'(w) : 8'h00);
        push_words(m);
        run0 = run_seen;
        apply_stimulus(m);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_output("ready low in run", 64'(msg_ready_o), 64'(0));
        end
        check_output("one run_o", 64'(run_seen - run0), 64'(1));
        check_output("word 16 literal", last_data[16], 64'd16);
        manual_done = 1'b1;
        @(negedge clk_i);
        manual_done = 1'b0;
        check_output("ready after run_done", 64'(msg_ready_o), 64'(1));
        pulse_clear();
        auto_run = 1'b1;

        $display("[TB] partial word AABBCC");
        m = rand_bytes(24);
        m.push_back(8'hCC); m.push_back(8'hBB); m.push_back(8'hAA);
        run_message(m);
        check_output("pad word literal", last_data[3], 64'h0000_0000_06AA_BBCC);
        check_output("zero word literal", last_data[9], 64'h0);
        check_output("final word literal", last_data[16], 64'h8000_0000_0000_0000);

        $display("[TB] 135 bytes, pad in last word");
        m = rand_bytes(128);
        for (int b = 0; b < 7; b++) m.push_back(8'(8'h77 - 8'h11 * b));
        base_w = n_writes;
        run_message(m);
        check_output("merged pad literal", last_data[16], 64'h8611_2233_4455_6677);
        check_output("no zero writes", 64'(n_writes - base_w), 64'(17));

        $display("[TB] 136 bytes, process during run");
        min_delay = 3;
        m = rand_bytes(RateBytes);
        run_message(m);
        min_delay = 0;
        check_output("pad-only word 0", last_data[0], 64'h06);
        check_output("pad-only word 8", last_data[8], 64'h0);
        check_output("pad-only word 16", last_data[16], 64'h80 << 56);

        $display("[TB] clear during zero fill");
        m = rand_bytes(16);
        push_words(pad_msg(m));
        run0 = run_seen;
        apply_stimulus(m);
        pulse_process();
        t = 0;
        do begin
            @(negedge clk_i);
            #1;
            t++;
        end while (!(keccak_valid_o && keccak_addr_o == BlockW'(9)) && t < 100);
        check_output("reached addr 9", 64'(keccak_addr_o), 64'(9));
        clear_i = 1'b1;
        @(posedge clk_i);
        #1 clear_i = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        check_output("ready after mid clear", 64'(msg_ready_o), 64'(1));
        repeat (20) @(negedge clk_i);
        check_output("no run after clear", 64'(run_seen - run0), 64'(0));

        $display("[TB] random messages");
        for (int i = 0; i < 12; i++) begin
            m = rand_bytes($urandom_range(0, 300));
            run_message(m);
        end

        $display("[TB] reset during run");
        auto_run = 1'b0;
        m = rand_bytes(RateBytes);
        push_words(m);
        apply_stimulus(m);
        t = 0;
        while (!run_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        check_output("run_o before reset", 64'(run_o), 64'(1));
        #2 rst_ni = 1'b0;
        #1;
        check_output("async reset ready", 64'(msg_ready_o), 64'(1));
        check_output("async reset valid", 64'(keccak_valid_o), 64'(0));
        check_output("async reset run_o", 64'(run_o), 64'(0));
        check_output("async reset absorbed", 64'(absorbed_o), 64'(0));
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        run0 = run_seen;
        abs0 = abs_seen;
        @(negedge clk_i);
        manual_done = 1'b1;
        @(negedge clk_i);
        manual_done = 1'b0;
        repeat (5) @(negedge clk_i);
        check_output("spurious done absorbed", 64'(abs_seen - abs0), 64'(0));
        check_output("spurious done run", 64'(run_seen - run0), 64'(0));
        auto_run = 1'b1;
        m = rand_bytes(50);
        run_message(m);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
